// File: rtl/mult_sat_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mult_sat_seq                                                    |
// | Brief    : iterative signed shift-add multiplier, rounded Q-scaling,       |
// |            saturating result with overflow flag, valid/ready both sides.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mult_sat_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = 2*WIDTH + 1;

  localparam logic signed [PW-1:0] c_max = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] c_min = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};
  // Half an LSB of the scaled result; collapses to zero when FRAC is 0.
  localparam logic signed [PW-1:0] c_rnd = ({{(PW-1){1'b0}}, 1'b1} << FRAC) >> 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 r_state;
  logic [2*WIDTH-1:0]     r_mcand;
  logic [2*WIDTH-1:0]     r_prod;
  logic [WIDTH-1:0]       r_mplier;
  logic                   r_sign;
  logic [CW-1:0]          r_cnt;

  logic [WIDTH-1:0]       w_abs_a;
  logic [WIDTH-1:0]       w_abs_b;
  logic signed [PW-1:0]   w_mag;
  logic signed [PW-1:0]   w_p;
  logic signed [PW-1:0]   w_sum;
  logic signed [PW-1:0]   w_r;
  logic                   w_pos;
  logic                   w_neg;

  // The most negative operand yields 2^(WIDTH-1), which still fits unsigned.
  assign w_abs_a = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign w_abs_b = b[WIDTH-1] ? (~b + 1'b1) : b;

  assign w_mag = {1'b0, r_prod};
  assign w_p   = r_sign ? -w_mag : w_mag;
  assign w_sum = w_p + c_rnd;
  assign w_r   = w_sum >>> FRAC;
  assign w_pos = (w_r > c_max);
  assign w_neg = (w_r < c_min);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_prod    <= '0;
      r_mplier  <= '0;
      r_sign    <= 1'b0;
      r_cnt     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y         <= '0;
      ovf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
            r_mplier <= w_abs_b;
            r_sign   <= a[WIDTH-1] ^ b[WIDTH-1];
            r_prod   <= '0;
            r_cnt    <= '0;
            in_ready <= 1'b0;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_mplier[0]) begin
            r_prod <= r_prod + r_mcand;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH-1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (w_pos) begin
            y <= {1'b0, {(WIDTH-1){1'b1}}};
          end else if (w_neg) begin
            y <= {1'b1, {(WIDTH-1){1'b0}}};
          end else begin
            y <= w_r[WIDTH-1:0];
          end
          ovf       <= w_pos | w_neg;
          out_valid <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          // Return to IDLE before re-opening the input side.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
